// File: rtl/sr_flop_bank.sv
// Bank of independent clocked SR flops with a selectable S=R=1 resolution,
// plus per-channel invalid-input flags, sticky flags and a saturating event counter.
module sr_flop_bank #(
  parameter int              WIDTH = 4,
  parameter int              MODE  = 0,
  parameter logic [WIDTH-1:0] INIT = '0,
  parameter int              CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_inv,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] inv,
  output logic [WIDTH-1:0] inv_sticky,
  output logic [CNT_W-1:0] inv_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] set_only;
  logic [WIDTH-1:0] rst_only;
  logic [WIDTH-1:0] both;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] inv_new;
  logic             any_inv;

  assign set_only = s & ~r;
  assign rst_only = r & ~s;
  assign both     = s & r;
  assign inv_new  = en ? both : '0;
  assign any_inv  = |inv_new;

  // MODE only changes what happens to channels with s=r=1.
  always_comb begin
    q_nxt = (q & ~rst_only) | set_only;
    case (MODE)
      0:       q_nxt = q_nxt & ~both;
      1:       q_nxt = q_nxt | both;
      2:       q_nxt = q_nxt;
      default: q_nxt = q_nxt ^ both;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= INIT;
      inv <= '0;
    end else if (en) begin
      q   <= q_nxt;
      inv <= both;
    end
  end

  // clr_inv wipes history first, so a same-edge event survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_sticky <= '0;
      inv_count  <= '0;
    end else if (clr_inv) begin
      inv_sticky <= inv_new;
      inv_count  <= any_inv ? CNT_W'(1) : '0;
    end else begin
      inv_sticky <= inv_sticky | inv_new;
      if (any_inv && inv_count != CNT_MAX)
        inv_count <= inv_count + CNT_W'(1);
    end
  end

  assign qbar = ~q;

endmodule

// File: tb/tb_sr_flop_bank.sv
// Directed bench: four MODE variants share one stimulus, plus a CNT_W=2 / nonzero-INIT copy.
module tb_sr_flop_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] s;
  logic [3:0] r;
  logic       clr_inv;

  logic [3:0] q_m    [4];
  logic [3:0] qbar_m [4];
  logic [3:0] inv_m  [4];
  logic [3:0] st_m   [4];
  logic [7:0] cnt_m  [4];

  logic [3:0] q_s, qbar_s, inv_s, st_s;
  logic [1:0] cnt_s;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sr_flop_bank #(.WIDTH(4), .MODE(0), .INIT(4'b0000), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_inv(clr_inv),
    .q(q_m[0]), .qbar(qbar_m[0]), .inv(inv_m[0]), .inv_sticky(st_m[0]), .inv_count(cnt_m[0]));
  sr_flop_bank #(.WIDTH(4), .MODE(1), .INIT(4'b0000), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_inv(clr_inv),
    .q(q_m[1]), .qbar(qbar_m[1]), .inv(inv_m[1]), .inv_sticky(st_m[1]), .inv_count(cnt_m[1]));
  sr_flop_bank #(.WIDTH(4), .MODE(2), .INIT(4'b0000), .CNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_inv(clr_inv),
    .q(q_m[2]), .qbar(qbar_m[2]), .inv(inv_m[2]), .inv_sticky(st_m[2]), .inv_count(cnt_m[2]));
  sr_flop_bank #(.WIDTH(4), .MODE(3), .INIT(4'b0000), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_inv(clr_inv),
    .q(q_m[3]), .qbar(qbar_m[3]), .inv(inv_m[3]), .inv_sticky(st_m[3]), .inv_count(cnt_m[3]));
  sr_flop_bank #(.WIDTH(4), .MODE(0), .INIT(4'b1001), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_inv(clr_inv),
    .q(q_s), .qbar(qbar_s), .inv(inv_s), .inv_sticky(st_s), .inv_count(cnt_s));

  // Inputs change 1ns after a rising edge and outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; s = 4'b0000; r = 4'b0000; clr_inv = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (q_m[i] !== 4'b0000 || qbar_m[i] !== 4'b1111 || inv_m[i] !== 4'b0000 ||
          st_m[i] !== 4'b0000 || cnt_m[i] !== 8'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_mode%0d q=%b qbar=%b inv=%b st=%b cnt=%0d want 0000/1111/0000/0000/0",
                 i, q_m[i], qbar_m[i], inv_m[i], st_m[i], cnt_m[i]);
      end
    end
    vectors++;
    if (q_s !== 4'b1001 || qbar_s !== 4'b0110 || cnt_s !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_init q=%b qbar=%b cnt=%0d want 1001/0110/0", q_s, qbar_s, cnt_s);
    end
    en = 1'b1; s = 4'b1111; r = 4'b1111; clr_inv = 1'b1;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (q_m[i] !== 4'b0000 || inv_m[i] !== 4'b0000 || cnt_m[i] !== 8'd0 || st_m[i] !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL reset_held_mode%0d q=%b inv=%b st=%b cnt=%0d want 0000/0000/0000/0",
                 i, q_m[i], inv_m[i], st_m[i], cnt_m[i]);
      end
    end
    s = 4'b0000; r = 4'b0000; clr_inv = 1'b0; en = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_set();
    en = 1'b1; s = 4'b0101; r = 4'b0000;
    step();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (q_m[i] !== 4'b0101 || qbar_m[i] !== 4'b1010 || inv_m[i] !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL set_mode%0d q=%b qbar=%b inv=%b want 0101/1010/0000",
                 i, q_m[i], qbar_m[i], inv_m[i]);
      end
    end
    vectors++;
    if (q_s !== 4'b1101) begin
      miscompares++;
      $display("[TB] FAIL set_init q=%b want 1101", q_s);
    end
  endtask

  task automatic test_invalid();
    logic [3:0] exp_q [4];
    exp_q = '{4'b0000, 4'b1111, 4'b0101, 4'b1010};
    en = 1'b1; s = 4'b1111; r = 4'b1111;
    step();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (q_m[i] !== exp_q[i] || qbar_m[i] !== ~exp_q[i] || inv_m[i] !== 4'b1111 ||
          st_m[i] !== 4'b1111 || cnt_m[i] !== 8'd1) begin
        miscompares++;
        $display("[TB] FAIL invalid_mode%0d q=%b qbar=%b inv=%b st=%b cnt=%0d want %b/%b/1111/1111/1",
                 i, q_m[i], qbar_m[i], inv_m[i], st_m[i], cnt_m[i], exp_q[i], ~exp_q[i]);
      end
    end
    s = 4'b0000; r = 4'b0000;
    step();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (q_m[i] !== exp_q[i] || inv_m[i] !== 4'b0000 || st_m[i] !== 4'b1111 || cnt_m[i] !== 8'd1) begin
        miscompares++;
        $display("[TB] FAIL invalid_after_mode%0d q=%b inv=%b st=%b cnt=%0d want %b/0000/1111/1",
                 i, q_m[i], inv_m[i], st_m[i], cnt_m[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_enable();
    logic [3:0] exp_q [4];
    exp_q = '{4'b0000, 4'b1111, 4'b0101, 4'b1010};
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s = 4'b1111;
      r = (k == 3) ? 4'b1111 : 4'b0000;
      step();
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (q_m[i] !== exp_q[i] || inv_m[i] !== 4'b0000 || cnt_m[i] !== 8'd1) begin
          miscompares++;
          $display("[TB] FAIL enable_mode%0d_edge%0d q=%b inv=%b cnt=%0d want %b/0000/1",
                   i, k, q_m[i], inv_m[i], cnt_m[i], exp_q[i]);
        end
      end
    end
    s = 4'b0000; r = 4'b0000;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5];
    logic [3:0] exp_q   [4];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    exp_q   = '{4'b0000, 4'b1111, 4'b0101, 4'b1011};
    en = 1'b1; clr_inv = 1'b1;
    step();
    clr_inv = 1'b0;
    vectors++;
    if (cnt_s !== 2'd0 || st_s !== 4'b0000 || cnt_m[0] !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL sat_preclear cnt_s=%0d st_s=%b cnt0=%0d want 0/0000/0", cnt_s, st_s, cnt_m[0]);
    end
    s = 4'b0001; r = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++;
      if (cnt_s !== exp_cnt[k] || cnt_m[0] !== 8'(k + 1) || inv_s !== 4'b0001) begin
        miscompares++;
        $display("[TB] FAIL sat_edge%0d cnt_s=%0d cnt0=%0d inv_s=%b want %0d/%0d/0001",
                 k, cnt_s, cnt_m[0], inv_s, exp_cnt[k], k + 1);
      end
    end
    vectors++;
    if (st_s !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL sat_sticky st_s=%b want 0001", st_s);
    end
    s = 4'b0000; r = 4'b0000; clr_inv = 1'b1;
    step();
    clr_inv = 1'b0;
    vectors++;
    if (cnt_s !== 2'd0 || st_s !== 4'b0000 || inv_s !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL sat_clear cnt_s=%0d st_s=%b inv_s=%b want 0/0000/0000", cnt_s, st_s, inv_s);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (q_m[i] !== exp_q[i]) begin
        miscompares++;
        $display("[TB] FAIL clr_keeps_q_mode%0d q=%b want %b", i, q_m[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_clr_collision();
    en = 1'b1; s = 4'b0001; r = 4'b0001;
    repeat (3) step();
    vectors++;
    if (cnt_s !== 2'd3) begin
      miscompares++;
      $display("[TB] FAIL collide_pre cnt_s=%0d want 3", cnt_s);
    end
    s = 4'b0100; r = 4'b0100; clr_inv = 1'b1;
    step();
    clr_inv = 1'b0; s = 4'b0000; r = 4'b0000;
    vectors++;
    if (cnt_s !== 2'd1 || st_s !== 4'b0100 || inv_s !== 4'b0100 ||
        cnt_m[0] !== 8'd1 || st_m[0] !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL collide cnt_s=%0d st_s=%b inv_s=%b cnt0=%0d st0=%b want 1/0100/0100/1/0100",
               cnt_s, st_s, inv_s, cnt_m[0], st_m[0]);
    end
    vectors++;
    if (q_m[3] !== 4'b1110) begin
      miscompares++;
      $display("[TB] FAIL collide_toggle q=%b want 1110", q_m[3]);
    end
  endtask

  task automatic test_back_to_back();
    en = 1'b1; s = 4'b0011; r = 4'b1100;
    step();
    s = 4'b1100; r = 4'b0011;
    step();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (q_m[i] !== 4'b1100 || qbar_m[i] !== 4'b0011) begin
        miscompares++;
        $display("[TB] FAIL b2b_mode%0d q=%b qbar=%b want 1100/0011", i, q_m[i], qbar_m[i]);
      end
    end
    s = 4'b0010; r = 4'b0100;
    step();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (q_m[i] !== 4'b1010) begin
        miscompares++;
        $display("[TB] FAIL independent_mode%0d q=%b want 1010", i, q_m[i]);
      end
    end
    s = 4'b0000; r = 4'b0000;
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (q_m[i] !== 4'b0000 || qbar_m[i] !== 4'b1111 || cnt_m[i] !== 8'd0 || st_m[i] !== 4'b0000) begin
        miscompares++;
        $display("[TB] FAIL async_rst_mode%0d q=%b qbar=%b cnt=%0d st=%b want 0000/1111/0/0000",
                 i, q_m[i], qbar_m[i], cnt_m[i], st_m[i]);
      end
    end
    vectors++;
    if (q_s !== 4'b1001 || cnt_s !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL async_rst_init q=%b cnt=%0d want 1001/0", q_s, cnt_s);
    end
    #1;
    rst = 1'b0; en = 1'b1; s = 4'b0001; r = 4'b0000;
    step();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (q_m[i] !== 4'b0001) begin
        miscompares++;
        $display("[TB] FAIL post_rst_mode%0d q=%b want 0001", i, q_m[i]);
      end
    end
    vectors++;
    if (q_s !== 4'b1001) begin
      miscompares++;
      $display("[TB] FAIL post_rst_init q=%b want 1001", q_s);
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_invalid();
    test_enable();
    test_saturation();
    test_clr_collision();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sr_flop_bank.md
SR_FLOP_BANK -- requirements
Module: sr_flop_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of independent SR channels (1..32).
REQ-002 The block SHALL have parameter MODE, default 0, setting the S=R=1 resolution: 0 reset-dominant, 1 set-dominant, 2 hold, 3 toggle.
REQ-003 The block SHALL have parameter INIT, default all-zero, WIDTH bits, giving the per-channel value of q after reset.
REQ-004 The block SHALL have parameter CNT_W, default 8, giving the width of the invalid-event counter.
REQ-005 Port: clk input 1, single clock; all state updates on its rising edge.
REQ-006 Port: rst input 1, asynchronous, active-high reset.
REQ-007 Port: en input 1, update enable; when 0, q holds for all channels.
REQ-008 Port: s input WIDTH, per-channel set request, active-high.
REQ-009 Port: r input WIDTH, per-channel reset request, active-high.
REQ-010 Port: clr_inv input 1, synchronous clear of inv_sticky and inv_count.
REQ-011 Port: q output WIDTH, registered channel state.
REQ-012 Port: qbar output WIDTH, always bitwise complement of q.
REQ-013 Port: inv output WIDTH, registered per-channel flag: S=R=1 sampled with en=1 in the previous cycle.
REQ-014 Port: inv_sticky output WIDTH, per-channel latched inv flag.
REQ-015 Port: inv_count output CNT_W, count of cycles in which any channel saw S=R=1 with en=1.

Function
REQ-016 With en=1, each channel SHALL update on the rising clk edge per its s,r: 00 hold, 10 q<=1, 01 q<=0, 11 per MODE.
REQ-017 For s=r=1, MODE 0 SHALL give q<=0, MODE 1 q<=1, MODE 2 hold, MODE 3 q<=~q.
REQ-018 Next-state latency SHALL be exactly one clock; no combinational path from s/r to q, qbar, or inv.
REQ-019 With en=0, q, qbar and inv SHALL hold their values; s=r=1 SHALL neither be flagged nor counted.
REQ-020 qbar SHALL equal ~q in every cycle, including reset and S=R=1 in any MODE (no both-zero NOR-latch state).
REQ-021 inv[i] SHALL be 1 for exactly the cycle after an en=1 edge with s[i]=r[i]=1, else 0.
REQ-022 inv_sticky[i] SHALL set on the same edge that sets inv[i] and stay 1 until clr_inv or rst.
REQ-023 inv_count SHALL increment by 1 per qualifying edge, regardless of how many channels are invalid that cycle.
REQ-024 inv_count SHALL saturate at 2^CNT_W-1 without wrap-around.
REQ-025 If clr_inv and a new invalid event share an edge, clr_inv SHALL win for the sticky/count clear, then inv_sticky SHALL equal that cycle's new inv bits and inv_count SHALL be 1.
REQ-026 clr_inv SHALL not affect q, qbar or inv.
REQ-027 Channels SHALL be fully independent; activity on one channel SHALL not change another channel's q.

Reset
REQ-028 Asserting rst SHALL immediately, without waiting for clk, force q=INIT, qbar=~INIT, inv=0, inv_sticky=0, inv_count=0.
REQ-029 While rst is high, all outputs SHALL hold reset values regardless of clk, en, s, r, clr_inv.
REQ-030 After rst deasserts, the first rising clk edge SHALL perform a normal update; rst asserted mid-sequence SHALL discard all prior state.

Verification
REQ-031 WIDTH=4, MODE=0, INIT=4'b0000: rst pulse, then s=4'b0101, r=0, en=1 for one edge -> q=4'b0101, qbar=4'b1010 after that edge.
REQ-032 From q=4'b0101: s=4'b1111, r=4'b1111, en=1 in MODE 0/1/2/3 -> q=4'b0000 / 4'b1111 / 4'b0101 / 4'b1010; inv=4'b1111 for one cycle; inv_count=1.
REQ-033 en=0 with s=4'b1111, r=4'b0000 for 3 edges -> q unchanged, inv=0, inv_count unchanged.
REQ-034 CNT_W=2: 5 consecutive en=1 edges with s[0]=r[0]=1 -> inv_count 1,2,3,3,3; inv_sticky=4'b0001; then clr_inv with s=r=0 -> inv_count=0, inv_sticky=0.
REQ-035 rst asserted between edges while q=4'b1010 -> q=INIT and inv_count=0 before next clk edge; rst released -> next edge with s=4'b0001, r=0 gives q=4'b0001.
REQ-036 clr_inv and s[2]=r[2]=1 on the same edge after inv_count=3 -> inv_count=1, inv_sticky=4'b0100.
